serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Bit-serial add/subtract sequencer that time-multiplexes a single 1-bit CLA cell across WIDTH cycles.
- Serves area-constrained paths in the FP ALU, such as mantissa alignment and exponent adjust, where a full-width adder is not justified.
- Owns operand shift registers, the carry register, bit counter and valid/ready handshakes on both sides.

Parameters:
WIDTH, 24, operand/result width in bits; legal range WIDTH >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand request valid
in_ready  out  1  block can accept an operand request this cycle
op_sub  in  1  0 = a+b, 1 = a-b; sampled at acceptance
a  in  WIDTH  operand A; sampled at acceptance
b  in  WIDTH  operand B; sampled at acceptance
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result, modulo 2^WIDTH
cout  out  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned)
ovf  out  1  two's-complement signed overflow
busy  out  1  high in RUN

Behaviour:
- Reset is asynchronous, active-low, and is the only reset. On assertion:
  - state = IDLE; out_valid, busy, sum, cout, ovf = 0.
  - Shift registers, carry register and counter = 0.
  - in_ready reads 1.
- States and transitions:
  - IDLE: in_ready = 1.
  - RUN: in_ready = 0; busy = 1.
  - DONE: out_valid = 1; in_ready = out_ready.
- Acceptance: in_valid & in_ready on a rising edge.
  - Load A_sr = a and B_sr = op_sub ? ~b : b.
  - Load carry = op_sub and cnt = 0.
  - Enter RUN. Acceptance in DONE also completes the output handshake in the same edge.
- RUN, each cycle:
  - Cell inputs are A_sr[0], B_sr[0], carry.
  - Cell Sum is shifted into S_sr at the MSB; A_sr and B_sr shift right.
  - carry <= cell Cout; cnt <= cnt+1.
- When cnt == WIDTH-1, on the same edge:
  - Capture the final bit.
  - cout <= cell Cout.
  - ovf <= carry-in to MSB XOR cell Cout.
  - sum <= final S_sr.
  - Go to DONE.
- Latency: out_valid rises exactly WIDTH cycles after the acceptance edge.
- Throughput: one op per WIDTH+1 cycles with out_ready tied high, via back-to-back acceptance from DONE.
- DONE: sum/cout/ovf stay stable while out_valid & !out_ready, with no limit on stall length.
  - out_valid & out_ready & !in_valid: go to IDLE; out_valid = 0; sum/cout/ovf hold their last values.
  - out_valid & out_ready & in_valid: go directly to RUN with the new operands.
- Inputs a, b and op_sub are ignored outside acceptance; changes during RUN/DONE have no effect.
- in_valid while busy is not accepted. No internal queuing: the requester holds in_valid until in_ready.
- Reset mid-RUN or mid-DONE discards the operation immediately. No out_valid is produced for it.
- Counter width is $clog2(WIDTH). There is no wrap-around beyond WIDTH-1, because the counter is reloaded on acceptance.

Decomposition:
- Shared ALU package holds:
  - State enum {IDLE, RUN, DONE}, 2-bit encoding 0/1/2.
  - Op-code constants OP_ADD=0 and OP_SUB=1.
- One sub-module: the existing 1-bit CLA cell, instantiated once as u_cell. No other sub-modules.
- Shift registers, counter and FSM live in serial_add_seq.

Test Plan:
- WIDTH=8, add 0x3C+0x21 -> sum 0x5D, cout 0, ovf 0; out_valid rises exactly 8 cycles after the acceptance edge; busy high for those 8 cycles.
- Add 0xFF+0x01 -> sum 0x00, cout 1, ovf 0. Then add 0x7F+0x01 -> sum 0x80, cout 0, ovf 1.
- Subtract 0x05-0x07 -> sum 0xFE, cout 0, ovf 0. Then subtract 0x80-0x01 -> sum 0x7F, cout 1, ovf 1.
- Backpressure, with in_valid held high carrying a second op throughout:
  - Hold out_ready=0 for 10 cycles in DONE -> sum/cout/ovf stable, in_ready 0, second op not accepted.
  - Raise out_ready -> second op accepted on that edge, out_valid drops next cycle; second result arrives 8 cycles later.
- Drop rst_n asynchronously at RUN cycle 3 of 0x3C+0x21 -> out_valid, sum, busy immediately 0 and in_ready 1. After release, a fresh 0x10+0x01 yields 0x11.
- Change a/b/op_sub every cycle during RUN -> result equals the values sampled at acceptance only.

Source files
------------

// File: rtl/serial_add_seq_pkg.sv
// Shared ALU definitions: sequencer state encoding and op-code constants.
package serial_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand request / result handshake bundle for the bit-serial add/subtract sequencer.
interface serial_add_seq_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, op_sub, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, op_sub, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/serial_add_seq_cell.sv
// 1-bit carry-lookahead cell: generate/propagate form of a full adder.
module serial_add_seq_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic g_s;
    logic p_s;

    assign g_s  = a & b;
    assign p_s  = a ^ b;
    assign s    = p_s ^ cin;
    assign cout = g_s | (p_s & cin);
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one CLA cell reused over WIDTH cycles,
// LSB first, with valid/ready handshakes on the request and result sides.
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_seq_if.slave bus
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    // Only WIDTH-1 bits are kept: the final bit goes straight into the sum capture.
    logic [WIDTH-2:0] s_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             out_valid_r;
    logic             busy_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             cell_sum_s;
    logic             cell_cout_s;
    logic [WIDTH-1:0] s_next_s;

    serial_add_seq_cell u_cell (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .cin  (carry_r),
        .s    (cell_sum_s),
        .cout (cell_cout_s)
    );

    // Accept in IDLE, or in DONE when the result is taken on the same edge.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            DONE:    in_ready_s = bus.out_ready;
            default: in_ready_s = 1'b0;
        endcase
        accept_s = bus.in_valid & in_ready_s;
        s_next_s = {cell_sum_s, s_sr_r};
    end

    // Sequencer FSM: operand load, per-bit shift/carry step, result capture, handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_sr_r      <= '0;
            b_sr_r      <= '0;
            s_sr_r      <= '0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (accept_s) begin
            a_sr_r      <= bus.a;
            b_sr_r      <= (bus.op_sub == OP_SUB) ? ~bus.b : bus.b;
            carry_r     <= (bus.op_sub == OP_SUB);
            cnt_r       <= '0;
            state_r     <= RUN;
            busy_r      <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                RUN: begin
                    a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
                    s_sr_r  <= s_next_s[WIDTH-1:1];
                    carry_r <= cell_cout_s;
                    cnt_r   <= cnt_r + CW'(1'b1);
                    if (cnt_r == CNT_LAST) begin
                        sum_r       <= s_next_s;
                        cout_r      <= cell_cout_s;
                        ovf_r       <= carry_r ^ cell_cout_s;
                        state_r     <= DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq at WIDTH=8: arithmetic, flags, latency,
// backpressure, asynchronous reset and input isolation during RUN.
module tb_serial_add_seq;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_add_seq_if #(.WIDTH(W)) bus ();

    serial_add_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, check exact latency/busy window, result flags, then consume it.
    task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                          input logic vsub, input logic [7:0] esum, input logic ecout,
                          input logic eovf, input bit scramble);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = va;
        bus.b         = vb;
        bus.op_sub    = vsub;
        bus.out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        for (int i = 1; i < W; i++) begin
            if (scramble) begin
                bus.a      = 8'($urandom);
                bus.b      = 8'($urandom);
                bus.op_sub = 1'($urandom);
            end
            @(posedge clk);
            #1;
            check({tag, "_no_valid_early"}, 32'({bus.out_valid, bus.busy}), 32'b01);
        end
        @(posedge clk);
        #1;
        check({tag, "_valid_busy"}, 32'({bus.out_valid, bus.busy}), 32'b10);
        check({tag, "_sum"}, 32'(bus.sum), 32'(esum));
        check({tag, "_flags"}, 32'({bus.cout, bus.ovf}), 32'({ecout, eovf}));
        @(posedge clk);
        #1;
        check({tag, "_consumed"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_sum_hold"}, 32'(bus.sum), 32'(esum));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("reset_outputs", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.ovf}),
              32'b10000);
        check("reset_sum", 32'(bus.sum), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_3c_21", 8'h3C, 8'h21, 1'b0, 8'h5D, 1'b0, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("scramble_a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h4B, 1'b1, 1'b1, 1'b1);

        // Backpressure: 0x12+0x34 stalls in DONE while 0x40-0x03 waits on in_valid.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = 8'h12;
        bus.b         = 8'h34;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.a      = 8'h40;
        bus.b      = 8'h03;
        bus.op_sub = 1'b1;
        repeat (W) @(posedge clk);
        #1 check("bp_first_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_stall_ctrl", 32'({bus.out_valid, bus.in_ready, bus.busy}), 32'b100);
            check("bp_stall_res", 32'({bus.sum, bus.cout, bus.ovf}), 32'({8'h46, 1'b0, 1'b0}));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1 check("bp_in_ready_follows", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_second_accepted", 32'({bus.out_valid, bus.busy}), 32'b01);
        repeat (W - 1) @(posedge clk);
        #1 check("bp_second_early", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("bp_second_valid", 32'(bus.out_valid), 32'd1);
        check("bp_second_res", 32'({bus.sum, bus.cout, bus.ovf}), 32'({8'h3D, 1'b1, 1'b0}));
        @(posedge clk);
        #1 check("bp_second_consumed", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of RUN discards the op.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 8'h3C;
        bus.b        = 8'h21;
        bus.op_sub   = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 32'({bus.out_valid, bus.busy, bus.in_ready}), 32'b001);
        check("rst_mid_sum", 32'(bus.sum), 32'd0);
        repeat (W + 2) @(posedge clk);
        #1 check("rst_no_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_10_01", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
